// File: rtl/pad_feed_ctrl_pkg.sv
// Shared definitions for the padder feed controller: FSM state encoding and
// frame-geometry helpers.
package pad_feed_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARM   = 3'd1,
        ST_FEED  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_FIN   = 3'd4
    } state_t;

    // Edge length of the frame as it leaves the padder.
    function automatic int padded(input int size, input int padding);
        return size + 2 * padding;
    endfunction

    function automatic int pixels(input int size);
        return size * size;
    endfunction

endpackage

// File: rtl/pad_feed_ctrl_issue_timer.sv
// Interval counter that paces pixel issue: a slot opens when the count is
// zero and the downstream is not stalling.
module issue_timer #(
    parameter int INTERVAL = 12
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    input  logic load,
    input  logic hold,
    output logic slot
);

    localparam int TW = (INTERVAL > 0) ? $clog2(INTERVAL + 1) : 1;

    logic [TW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= TW'(INTERVAL);
        end else if (en && !hold && (r_cnt != '0)) begin
            r_cnt <= r_cnt - TW'(1);
        end
    end

    assign slot = en && !hold && (r_cnt == '0);

endmodule

// File: rtl/pad_feed_ctrl.sv
// Streams one feature-map frame from the feature buffer into the padder,
// one pixel every CLK_INTERVAL+1 cycles, then waits for the padder to finish.
module pad_feed_ctrl
    import pad_feed_ctrl_pkg::*;
#(
    parameter int N            = 8,
    parameter int CHANNEL      = 3,
    parameter int SIZE         = 32,
    parameter int PADDING      = 1,
    parameter int CLK_INTERVAL = 12,
    parameter int ADDR_W       = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [ADDR_W-1:0]      base_addr,
    input  logic                   hold,
    output logic                   mem_rd_en,
    output logic [ADDR_W-1:0]      mem_addr,
    input  logic [CHANNEL*N-1:0]   mem_rdata,
    output logic                   pad_ce,
    output logic                   pad_vld,
    output logic [CHANNEL*N-1:0]   pad_din,
    input  logic                   pad_end,
    output logic                   busy,
    output logic                   done,
    output state_t                 dbg_state
);

    localparam int PIXELS = pixels(SIZE);
    localparam int PADDED = padded(SIZE, PADDING);
    localparam int PIX_W  = $clog2(PIXELS + 1);
    localparam int DW     = CHANNEL * N;

    // A negative border would make the padder shrink the frame; such a
    // configuration elaborates nothing extra but stays visible here.
    if (PADDED < SIZE) begin : g_negative_padding
    end

    state_t            r_state;
    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [PIX_W-1:0]  r_pix_idx;
    logic              r_mem_rd_en;
    logic              r_pad_ce;
    logic              r_pad_vld;
    logic [DW-1:0]     r_pad_din;
    logic              r_busy;
    logic              r_done;
    logic              r_seen_low;

    logic w_in_feed;
    logic w_slot;
    logic w_issue;
    logic w_last_out;

    assign w_in_feed = (r_state == ST_FEED);

    issue_timer #(
        .INTERVAL (CLK_INTERVAL)
    ) u_issue_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (!w_in_feed),
        .en    (w_in_feed),
        .load  (w_issue),
        .hold  (hold),
        .slot  (w_slot)
    );

    assign w_issue = w_slot && (r_pix_idx < PIX_W'(PIXELS));

    // The final pad_vld is the one seen once every pixel is issued and no
    // read is still in flight.
    assign w_last_out = (r_pix_idx == PIX_W'(PIXELS)) && r_pad_vld && !r_mem_rd_en;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_base      <= '0;
            r_mem_addr  <= '0;
            r_pix_idx   <= '0;
            r_mem_rd_en <= 1'b0;
            r_pad_ce    <= 1'b0;
            r_pad_vld   <= 1'b0;
            r_pad_din   <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_seen_low  <= 1'b0;
        end else begin
            r_mem_rd_en <= 1'b0;
            r_done      <= 1'b0;
            r_pad_vld   <= r_mem_rd_en;
            if (r_pad_vld) begin
                r_pad_din <= mem_rdata;
            end

            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_base     <= base_addr;
                        r_pix_idx  <= '0;
                        r_seen_low <= 1'b0;
                        r_busy     <= 1'b1;
                        r_pad_ce   <= 1'b1;
                        r_state    <= ST_ARM;
                    end
                end
                ST_ARM: begin
                    r_state <= ST_FEED;
                end
                ST_FEED: begin
                    if (w_issue) begin
                        r_mem_rd_en <= 1'b1;
                        r_mem_addr  <= r_base + ADDR_W'(r_pix_idx);
                        r_pix_idx   <= r_pix_idx + PIX_W'(1);
                    end
                    if (w_last_out) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // Completion is the padder's pad_end rising, not its level.
                    if (!pad_end) begin
                        r_seen_low <= 1'b1;
                    end else if (r_seen_low) begin
                        r_done   <= 1'b1;
                        r_busy   <= 1'b0;
                        r_pad_ce <= 1'b0;
                        r_state  <= ST_FIN;
                    end
                end
                ST_FIN: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_rd_en = r_mem_rd_en;
    assign mem_addr  = r_mem_addr;
    assign pad_ce    = r_pad_ce;
    assign pad_vld   = r_pad_vld;
    // Read data arrives the cycle after the strobe; present it with pad_vld
    // and keep the last pixel on the bus otherwise.
    assign pad_din   = r_pad_vld ? mem_rdata : r_pad_din;
    assign busy      = r_busy;
    assign done      = r_done;
    assign dbg_state = r_state;

endmodule
